// File: rtl/wb_sram_1rw_ctrl.sv
// Wishbone classic slave driving a single-port 1RW OpenRAM macro (256 x 32, byte mask).
// One bus transfer becomes exactly one registered SRAM port access followed by a one-cycle ack.
module wb_sram_1rw_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam int HIT_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_reg, state_next;
    logic                    op_we_reg, op_we_next;
    logic                    abort_reg, abort_next;
    logic                    ack_reg, ack_next;
    logic [DATA_WIDTH-1:0]   dat_o_reg, dat_o_next;
    logic                    csb_reg, csb_next;
    logic                    web_reg, web_next;
    logic [NUM_WMASKS-1:0]   wmask_reg, wmask_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   din_reg, din_next;

    logic                    req_hit;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_WMASKS-1:0]   req_wmask;
    logic [1:0]              adr_unused;

    // Byte lane bits of the address carry no meaning for a word-wide macro.
    assign adr_unused = wbs_adr_i[1:0];

    assign req_hit  = wbs_cyc_i && wbs_stb_i &&
                      (wbs_adr_i[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB]);
    assign req_addr = wbs_adr_i[HIT_LSB-1:2];

    // A read must never present a nonzero mask to the macro.
    generate
        for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_wmask
            assign req_wmask[gi] = wbs_we_i & wbs_sel_i[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        op_we_next = op_we_reg;
        abort_next = abort_reg;
        ack_next   = 1'b0;
        dat_o_next = dat_o_reg;
        csb_next   = csb_reg;
        web_next   = web_reg;
        wmask_next = wmask_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;

        case (state_reg)
            IDLE: begin
                if (req_hit) begin
                    addr_next  = req_addr;
                    din_next   = wbs_dat_i;
                    wmask_next = req_wmask;
                    web_next   = ~wbs_we_i;
                    csb_next   = 1'b0;
                    op_we_next = wbs_we_i;
                    abort_next = 1'b0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The macro samples the port at the end of this cycle; release it right after.
                csb_next   = 1'b1;
                web_next   = 1'b1;
                abort_next = ~wbs_cyc_i;
                if (!op_we_reg) begin
                    state_next = WAIT;
                end else if (wbs_cyc_i) begin
                    ack_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                dat_o_next = sram_dout0;
                if (abort_reg || !wbs_cyc_i) begin
                    state_next = IDLE;
                end else begin
                    ack_next   = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            op_we_reg <= 1'b0;
            abort_reg <= 1'b0;
            ack_reg   <= 1'b0;
            dat_o_reg <= '0;
            csb_reg   <= 1'b1;
            web_reg   <= 1'b1;
            wmask_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_we_reg <= op_we_next;
            abort_reg <= abort_next;
            ack_reg   <= ack_next;
            dat_o_reg <= dat_o_next;
            csb_reg   <= csb_next;
            web_reg   <= web_next;
            wmask_reg <= wmask_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
        end
    end

    assign wbs_ack_o   = ack_reg;
    assign wbs_dat_o   = dat_o_reg;
    assign sram_csb0   = csb_reg;
    assign sram_web0   = web_reg;
    assign sram_wmask0 = wmask_reg;
    assign sram_addr0  = addr_reg;
    assign sram_din0   = din_reg;

endmodule

// File: tb/tb_wb_sram_1rw_ctrl.sv
// Directed bench for wb_sram_1rw_ctrl: behavioural macro, cycle-indexed reference model
// of bus/port timing, and a per-cycle compare process.
module tb_wb_sram_1rw_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat_i = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [7:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 32'hBADC_0FFE;

    always #5 clk = ~clk;

    wb_sram_1rw_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .sram_csb0   (csb),
        .sram_web0   (web),
        .sram_wmask0 (wmask),
        .sram_addr0  (addr0),
        .sram_din0   (din0),
        .sram_dout0  (dout0)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cycle, act, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    // Behavioural macro: samples on rise, acts on fall, output goes stale after the next rise.
    bit   [31:0] mac_mem [256];
    logic        m_csb = 1'b1, m_web = 1'b1;
    logic [3:0]  m_wm;
    logic [7:0]  m_a;
    logic [31:0] m_d;

    always @(posedge clk) begin
        m_csb = csb; m_web = web; m_wm = wmask; m_a = addr0; m_d = din0;
    end
    always @(posedge clk) begin
        #1 dout0 = 32'hBADC_0FFE;
    end
    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < 4; b++)
                    if (m_wm[b]) mac_mem[m_a][8*b +: 8] = m_d[8*b +: 8];
            end else begin
                dout0 = mac_mem[m_a];
            end
        end
    end

    // Reference model: memory contents plus expected outputs keyed by cycle number.
    typedef struct {
        logic        web;
        logic [3:0]  wm;
        logic [7:0]  a;
        logic [31:0] d;
    } port_t;

    logic [31:0] ref_mem [256];
    bit          exp_ack [int];
    port_t       exp_port [int];
    logic [31:0] exp_dat_at [int];
    logic [31:0] exp_dat = 32'h0;
    bit          chk_en = 1'b0;
    int          ack_seen = 0;
    int          csb_seen = 0;

    always @(negedge clk) begin : compare
        port_t p;
        bit    drv;
        if (chk_en) begin
            if (exp_dat_at.exists(cycle)) exp_dat = exp_dat_at[cycle];
            drv = exp_port.exists(cycle);
            chk("ack", {31'h0, ack}, {31'h0, exp_ack.exists(cycle)});
            chk("csb0", {31'h0, csb}, {31'h0, !drv});
            if (drv) begin
                p = exp_port[cycle];
                chk("web0", {31'h0, web}, {31'h0, p.web});
                chk("addr0", {24'h0, addr0}, {24'h0, p.a});
                chk("wmask0", {28'h0, wmask}, {28'h0, p.wm});
                chk("din0", din0, p.d);
            end else begin
                chk("web0_idle", {31'h0, web}, 32'h1);
            end
            chk("dat_o", dat_o, exp_dat);
            if (ack) ack_seen++;
            if (!csb) csb_seen++;
        end
    end

    // Drive a request in the current cycle (c0) and record what the bus rules predict for it.
    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit no_ack, output int c0);
        logic [7:0] wa;
        c0 = cycle;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        wa = a[9:2];
        if (a[31:10] == BASE[31:10]) begin
            exp_port[c0 + 1] = '{web: !w, wm: (w ? s : 4'h0), a: wa, d: d};
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
                if (!no_ack) exp_ack[c0 + 2] = 1'b1;
            end else begin
                exp_dat_at[c0 + 3] = ref_mem[wa];
                if (!no_ack) exp_ack[c0 + 3] = 1'b1;
            end
        end
    endtask

    task automatic wait_ack(output logic [31:0] rd);
        bit seen = 1'b0;
        rd = 32'h0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (ack) begin
                seen = 1'b1;
                rd = dat_o;
            end
        end
        chk("ack_wait", {31'h0, seen}, 32'h1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        int c0;
        start_req(w, a, d, s, 1'b0, c0);
        if (a[31:10] == BASE[31:10]) begin
            wait_ack(rd);
        end else begin
            rd = 32'h0;
            repeat (8) @(posedge clk);
            #1;
            cyc = 1'b0; stb = 1'b0;
        end
        $display("xfer %s adr=%h dat=%h sel=%h rd=%h", w ? "WR" : "RD", a, d, s, rd);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        int          c0;
        int          a0, s0;
        logic [7:0]  wd;

        for (int i = 0; i < 256; i++) begin
            mac_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_csb", {31'h0, csb}, 32'h1);
        chk("rst_web", {31'h0, web}, 32'h1);
        chk("rst_wmask", {28'h0, wmask}, 32'h0);
        chk("rst_addr", {24'h0, addr0}, 32'h0);
        chk("rst_din", din0, 32'h0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Basic write then read back.
        start_req(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, c0);
        @(posedge clk); #1;
        chk("wr_cyc1_csb", {31'h0, csb}, 32'h0);
        chk("wr_cyc1_addr", {24'h0, addr0}, 32'h4);
        chk("wr_cyc1_wmask", {28'h0, wmask}, 32'hF);
        chk("wr_cyc1_web", {31'h0, web}, 32'h0);
        wait_ack(rd);
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);

        // Byte-masked write and an all-zero-select write.
        xfer(1'b1, 32'h3000_0000, 32'h1122_3344, 4'hF, rd);
        xfer(1'b1, 32'h3000_0000, 32'hAABB_CCDD, 4'b0101, rd);
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd);
        chk("masked_rd", rd, 32'h11BB_33DD);
        xfer(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'h0, rd);
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd);
        chk("sel0_rd", rd, 32'h11BB_33DD);

        // Misses: neither may ack nor touch the macro.
        a0 = ack_seen; s0 = csb_seen;
        xfer(1'b1, 32'h3000_0400, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF, rd);
        chk("miss_acks", ack_seen - a0, 32'h0);
        chk("miss_csb", csb_seen - s0, 32'h0);
        xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd);
        chk("miss_nowrite", rd, 32'h11BB_33DD);

        // Read aborted in ISSUE: data still captured, no ack, IDLE by cycle 3.
        xfer(1'b1, 32'h3000_0080, 32'h5A5A_5A5A, 4'hF, rd);
        start_req(1'b0, 32'h3000_0080, 32'h0, 4'hF, 1'b1, c0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_dat", dat_o, 32'h5A5A_5A5A);
        xfer(1'b0, 32'h3000_0080, 32'h0, 4'hF, rd);
        chk("abort_reread", rd, 32'h5A5A_5A5A);

        // Reset while a read sits in WAIT.
        start_req(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b1, c0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        exp_dat_at[c0 + 3] = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_ack", {31'h0, ack}, 32'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        chk("mid_rst_csb", {31'h0, csb}, 32'h1);
        chk("mid_rst_addr", {24'h0, addr0}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        xfer(1'b1, 32'h3000_0004, 32'h0123_4567, 4'hF, rd);
        xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, rd);
        chk("post_rst_rd", rd, 32'h0123_4567);

        // Back-to-back write/read sweep over every word.
        a0 = ack_seen; s0 = csb_seen;
        for (int i = 0; i < 256; i++) begin
            wd = i[7:0];
            xfer(1'b1, BASE + {22'h0, wd, 2'b00}, ~{24'h0, wd}, 4'hF, rd);
            xfer(1'b0, BASE + {22'h0, wd, 2'b00}, 32'h0, 4'hF, rd);
            chk("b2b_rd", rd, ~{24'h0, wd});
        end
        @(negedge clk);
        chk("b2b_acks", ack_seen - a0, 32'd512);
        chk("b2b_csb", csb_seen - s0, 32'd512);

        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
